// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end for a single system clock domain.
// Synchronizes SCK/MOSI/CS, shifts bytes in and out, handshakes TX data.
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       int_clk_i,
  input  logic       int_mosi_i,
  input  logic       int_cs_i,
  output logic       int_miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  output logic [7:0] byte_cnt_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       frame_end_o,
  output logic       frame_abort_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic [SW-1:0]          settle;
  logic                   armed;

  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] hold;
  logic       hold_full;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       load_pend;
  logic       first;

  logic s_sck;
  logic s_mosi;
  logic s_cs;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;
  logic cs_fall_go;
  logic cs_rise_go;
  logic sck_rise_go;
  logic sck_fall_go;
  logic tx_load;
  logic tx_accept;

  assign s_sck  = sck_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];
  assign s_cs   = cs_sync[SYNC_STAGES-1];

  always_comb begin
    sck_rise    = s_sck & ~sck_q;
    sck_fall    = ~s_sck & sck_q;
    cs_fall     = ~s_cs & cs_q;
    cs_rise     = s_cs & ~cs_q;
    // A CS fall only counts once CS has been seen high after reset
    cs_fall_go  = (state == IDLE) & cs_fall & armed;
    cs_rise_go  = (state == ACTIVE) & cs_rise;
    sck_rise_go = (state == ACTIVE) & ~cs_rise & sck_rise;
    sck_fall_go = (state == ACTIVE) & ~cs_rise & sck_fall;
    tx_load     = cs_fall_go | (sck_fall_go & load_pend);
    tx_accept   = tx_valid_i & ~hold_full;
  end

  assign tx_ready_o = ~hold_full;
  assign int_miso_o = (state == ACTIVE) & tx_sh[7];

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state         <= IDLE;
      sck_sync      <= '0;
      mosi_sync     <= '0;
      cs_sync       <= '1;
      sck_q         <= 1'b0;
      cs_q          <= 1'b1;
      settle        <= '0;
      armed         <= 1'b0;
      rx_sh         <= '0;
      tx_sh         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      bit_cnt       <= '0;
      byte_done     <= 1'b0;
      load_pend     <= 1'b0;
      first         <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_first_o    <= 1'b0;
      byte_cnt_o    <= '0;
      tx_underrun_o <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], int_clk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], int_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], int_cs_i};
      sck_q     <= s_sck;
      cs_q      <= s_cs;

      if (settle != SETTLE) settle <= settle + 1'b1;
      else if (s_cs) armed <= 1'b1;

      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_abort_o <= 1'b0;
      byte_done     <= 1'b0;

      if (byte_done) begin
        rx_data_o  <= rx_sh;
        rx_valid_o <= 1'b1;
        rx_first_o <= first;
        first      <= 1'b0;
        if (byte_cnt_o != 8'hFF) byte_cnt_o <= byte_cnt_o + 8'd1;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall_go) begin
            state      <= ACTIVE;
            bit_cnt    <= '0;
            byte_cnt_o <= '0;
            first      <= 1'b1;
            load_pend  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise_go) begin
            state         <= IDLE;
            frame_end_o   <= 1'b1;
            frame_abort_o <= (bit_cnt != 3'd0);
            bit_cnt       <= '0;
            load_pend     <= 1'b0;
          end else begin
            if (sck_rise_go) begin
              rx_sh   <= {rx_sh[6:0], s_mosi};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                load_pend <= 1'b1;
              end
            end
            if (sck_fall_go && load_pend) load_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (tx_load) begin
        if (hold_full) begin
          tx_sh     <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_sh         <= '0;
          tx_underrun_o <= 1'b1;
        end
      end else if (sck_fall_go) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (tx_accept) begin
        hold      <= tx_data_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
